dynamic_adder_scheduler: RTL and testbench

//  Shares one adder_16 dynamic adder between NUM_REQ requesters using round-robin arbitration.

---
 rtl/dynamic_adder_scheduler_if.sv | 42 ++++
 rtl/dynamic_adder_scheduler.sv | 127 ++++++++++++
 tb/tb_dynamic_adder_scheduler.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/dynamic_adder_scheduler_if.sv
// Bundles the requester, response and adder-side signals of dynamic_adder_scheduler.
// slave is the scheduler's view; master is the view of whatever surrounds it (requesters, consumer, adder).
interface dynamic_adder_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 6
);
  logic [NUM_REQ-1:0]    req;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_cin;
  logic [NUM_REQ-1:0]    req_ack;
  // Response handshake: resp_valid rises with the result and holds it, along with every resp_*
  // field, unchanged until a cycle where resp_valid && resp_ready, which is the single transfer cycle.
  logic                  resp_valid;
  logic                  resp_ready;
  logic [2:0]            resp_id;
  logic [15:0]           resp_sum;
  logic                  resp_cout;
  logic [CNT_W-1:0]      resp_cycles;
  logic                  resp_timeout;
  logic [15:0]           add_A;
  logic [15:0]           add_B;
  logic                  add_Cin;
  logic                  add_F;
  logic                  add_request;
  logic [15:0]           add_sum;
  logic                  add_cout;
  logic                  add_valid;
  logic [1:0]            dbg_state;

  modport slave (
    input  req, req_a, req_b, req_cin, resp_ready, add_sum, add_cout, add_valid,
    output req_ack, resp_valid, resp_id, resp_sum, resp_cout, resp_cycles, resp_timeout,
           add_A, add_B, add_Cin, add_F, add_request, dbg_state
  );

  modport master (
    output req, req_a, req_b, req_cin, resp_ready, add_sum, add_cout, add_valid,
    input  req_ack, resp_valid, resp_id, resp_sum, resp_cout, resp_cycles, resp_timeout,
           add_A, add_B, add_Cin, add_F, add_request, dbg_state
  );
endinterface

// File: rtl/dynamic_adder_scheduler.sv
// Round-robin scheduler sharing one self-timed 16-bit adder between NUM_REQ requesters,
// returning each captured result with the number of EVAL cycles it took.
module dynamic_adder_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int F_CYCLES = 2,
  parameter int MAX_WAIT = 32,
  parameter int CNT_W    = 6
) (
  input logic clk,
  input logic rst,
  dynamic_adder_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, EVAL = 2'd2, DONE = 2'd3} state_t;

  localparam int F_W     = (F_CYCLES > 1) ? $clog2(F_CYCLES) : 1;
  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  state_t             state, state_nx;
  logic [2:0]         ptr, id;
  logic [15:0]        a_q, b_q, sum_q;
  logic               cin_q, cout_q, timeout_q;
  logic [F_W-1:0]     f_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]   cycles_q, cycles_sat;
  logic               grant_found;
  logic [2:0]         grant_id;
  logic               eval_end;

  // Winner is the first requester above the pointer, wrapping; pointer = last served.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_id    = 3'd0;
    idx         = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && bus.req[idx]) begin
        grant_found = 1'b1;
        grant_id    = 3'(idx);
      end
    end
  end

  assign eval_end = bus.add_valid || (wait_cnt == WAIT_W'(MAX_WAIT));

  always_comb begin
    if (32'(wait_cnt) > 32'(CNT_MAX)) cycles_sat = CNT_W'(CNT_MAX);
    else                              cycles_sat = CNT_W'(wait_cnt);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_found) state_nx = LAUNCH;
      LAUNCH:  if (f_cnt == F_W'(F_CYCLES - 1)) state_nx = EVAL;
      EVAL:    if (eval_end) state_nx = DONE;
      DONE:    if (bus.resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'(NUM_REQ - 1);
      id        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      f_cnt     <= '0;
      wait_cnt  <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      cycles_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (grant_found) begin
          id    <= grant_id;
          a_q   <= bus.req_a[16*int'(grant_id) +: 16];
          b_q   <= bus.req_b[16*int'(grant_id) +: 16];
          cin_q <= bus.req_cin[grant_id];
          f_cnt <= '0;
        end
        LAUNCH: begin
          f_cnt    <= f_cnt + 1'b1;
          wait_cnt <= WAIT_W'(1);
        end
        EVAL: begin
          // On timeout the adder's outputs are captured as-is; resp_timeout flags them.
          if (eval_end) begin
            sum_q     <= bus.add_sum;
            cout_q    <= bus.add_cout;
            cycles_q  <= cycles_sat;
            timeout_q <= !bus.add_valid;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: if (bus.resp_ready) begin
          ptr   <= id;
          a_q   <= '0;
          b_q   <= '0;
          cin_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ack      = (state == LAUNCH && f_cnt == '0) ? (NUM_REQ'(1) << id) : '0;
  assign bus.add_F        = (state == LAUNCH);
  assign bus.add_request  = (state == EVAL);
  assign bus.add_A        = a_q;
  assign bus.add_B        = b_q;
  assign bus.add_Cin      = cin_q;
  assign bus.resp_valid   = (state == DONE);
  assign bus.resp_id      = (state == DONE) ? id : 3'd0;
  assign bus.resp_sum     = (state == DONE) ? sum_q : 16'd0;
  assign bus.resp_cout    = (state == DONE) && cout_q;
  assign bus.resp_cycles  = (state == DONE) ? cycles_q : '0;
  assign bus.resp_timeout = (state == DONE) && timeout_q;
  assign bus.dbg_state    = state;
endmodule

// File: tb/tb_dynamic_adder_scheduler.sv
// Directed bench for dynamic_adder_scheduler with a behavioural self-timed adder whose
// completion delay (in EVAL cycles) is set per operation.
module tb_dynamic_adder_scheduler;
  logic clk;
  logic rst;
  int   n_pass = 0;
  int   n_checks = 0;
  int   valid_delay = 1;
  bit   valid_off = 1'b0;
  int   ecnt = 0;
  logic [19:0] exp_q[$];
  logic [15:0] exp_sum[4];
  logic        exp_cout[4];

  dynamic_adder_scheduler_if #(.NUM_REQ(4), .CNT_W(6)) bus ();

  dynamic_adder_scheduler #(.NUM_REQ(4), .F_CYCLES(2), .MAX_WAIT(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / adder model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= bus.add_request ? ecnt + 1 : 0;
  assign {bus.add_cout, bus.add_sum} = 17'(bus.add_A) + 17'(bus.add_B) + 17'(bus.add_Cin);
  assign bus.add_valid = bus.add_request && !valid_off && (ecnt + 1 >= valid_delay);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b, input logic c);
    bus.req_a[16*i +: 16] = a;
    bus.req_b[16*i +: 16] = b;
    bus.req_cin[i]        = c;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] mask, input bit keep,
                        output logic [3:0] ack, output int lat, output int fcnt);
    bus.req = mask;
    lat  = 0;
    fcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.req_ack != 0) break;
    end
    ack = bus.req_ack;
    if (bus.add_F) fcnt++;
    if (!keep) bus.req = '0;
    while (!bus.resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.add_F) fcnt++;
    end
  endtask

  task automatic release_resp();
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("idle_gap_valid", 32'(bus.resp_valid), 0);
    check("idle_gap_state", 32'(bus.dbg_state), 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, 32'(bus.resp_valid), 0);
    check({tag, "_ack"},   32'(bus.req_ack), 0);
    check({tag, "_f"},     32'(bus.add_F), 0);
    check({tag, "_req"},   32'(bus.add_request), 0);
    check({tag, "_a"},     32'(bus.add_A), 0);
    check({tag, "_sum"},   32'(bus.resp_sum), 0);
    check({tag, "_state"}, 32'(bus.dbg_state), 0);
  endtask

  initial begin
    logic [3:0] ack;
    int lat, fcnt, id;
    logic [19:0] exp;
    bit saw_valid;

    rst = 1'b1;
    bus.req = '0; bus.req_a = '0; bus.req_b = '0; bus.req_cin = '0; bus.resp_ready = 1'b0;
    exp_sum[0] = 16'h0031; exp_cout[0] = 1'b0;
    exp_sum[1] = 16'h0000; exp_cout[1] = 1'b1;
    exp_sum[2] = 16'h5556; exp_cout[2] = 1'b0;
    exp_sum[3] = 16'h1000; exp_cout[3] = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check_quiet("rst");
    rst = 1'b0;

    // single op on requester 0, adder completes on the 3rd EVAL cycle
    set_ops(0, 16'h0001, 16'h0002, 1'b0);
    valid_delay = 3;
    run_op(4'b0001, 1'b0, ack, lat, fcnt);
    check("t1_ack", 32'(ack), 32'h1);
    check("t1_f_cycles", 32'(fcnt), 2);
    check("t1_latency", 32'(lat), 5);
    check("t1_sum", 32'(bus.resp_sum), 32'h0003);
    check("t1_cout", 32'(bus.resp_cout), 0);
    check("t1_cycles", 32'(bus.resp_cycles), 3);
    check("t1_timeout", 32'(bus.resp_timeout), 0);
    check("t1_id", 32'(bus.resp_id), 0);
    release_resp();
    check("t1_operands_cleared", 32'(bus.add_A), 0);

    // carry-out, minimum latency, and response held under back-pressure
    set_ops(1, 16'hFFFF, 16'h0001, 1'b0);
    valid_delay = 1;
    run_op(4'b0010, 1'b0, ack, lat, fcnt);
    check("t3_ack", 32'(ack), 32'h2);
    check("t3_min_latency", 32'(lat), 3);
    for (int c = 0; c < 5; c++) begin
      check("t3_hold_valid", 32'(bus.resp_valid), 1);
      check("t3_hold_sum", 32'(bus.resp_sum), 32'h0000);
      check("t3_hold_cout", 32'(bus.resp_cout), 1);
      check("t3_hold_cycles", 32'(bus.resp_cycles), 1);
      check("t3_hold_id", 32'(bus.resp_id), 1);
      check("t3_hold_a", 32'(bus.add_A), 32'hFFFF);
      @(negedge clk);
    end
    release_resp();

    // round-robin over four persistent requesters after a fresh reset
    do_reset();
    set_ops(0, 16'h0010, 16'h0020, 1'b1);
    set_ops(1, 16'h8000, 16'h8000, 1'b0);
    set_ops(2, 16'h1234, 16'h4321, 1'b1);
    set_ops(3, 16'h00FF, 16'h0F01, 1'b0);
    for (int op = 0; op < 8; op++) exp_q.push_back({3'(op % 4), exp_cout[op % 4], exp_sum[op % 4]});
    for (int op = 0; op < 8; op++) begin
      valid_delay = (op % 3) + 1;
      run_op(4'b1111, 1'b1, ack, lat, fcnt);
      exp = exp_q.pop_front();
      id  = int'(exp[19:17]);
      check("t4_ack", 32'(ack), 32'(1 << id));
      check("t4_resp", 32'({bus.resp_id, bus.resp_cout, bus.resp_sum}), 32'(exp));
      check("t4_cycles", 32'(bus.resp_cycles), 32'(valid_delay));
      release_resp();
    end
    bus.req = '0;

    // adder never completes: forced completion at MAX_WAIT
    valid_off = 1'b1;
    run_op(4'b0100, 1'b0, ack, lat, fcnt);
    check("t5_ack", 32'(ack), 32'h4);
    check("t5_latency", 32'(lat), 34);
    check("t5_timeout", 32'(bus.resp_timeout), 1);
    check("t5_cycles", 32'(bus.resp_cycles), 32);
    check("t5_id", 32'(bus.resp_id), 2);
    release_resp();

    // reset during EVAL abandons the op
    bus.req = 4'b1000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.add_request) break;
    end
    check("t6_in_eval", 32'(bus.add_request), 1);
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("t6_rst");
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.resp_valid) saw_valid = 1'b1;
    end
    check("t6_no_resp", 32'(saw_valid), 0);
    valid_off   = 1'b0;
    valid_delay = 2;
    run_op(4'b0100, 1'b0, ack, lat, fcnt);
    check("t6_ack", 32'(ack), 32'h4);
    check("t6_resp", 32'({bus.resp_id, bus.resp_cout, bus.resp_sum}), 32'({3'd2, 1'b0, 16'h5556}));
    check("t6_cycles", 32'(bus.resp_cycles), 2);
    check("t6_timeout", 32'(bus.resp_timeout), 0);
    release_resp();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
